game_primitives: RTL and testbench

GAME_PRIMITIVES -- requirements
Module: game_primitives

---
 rtl/game_primitives.sv | 96 +++++++++
 tb/tb_game_primitives.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_primitives.sv
// Game helpers: periodic strobe, registered rectangle-overlap detector and Fibonacci LFSR.
// Define GAME_PRIMITIVES_COLL_INCLUSIVE_EN to make touching rectangle edges count as a collision.
module game_primitives #(
  parameter int unsigned CLK_FREQ_HZ    = 50000000,
  parameter int unsigned STROBE_FREQ_HZ = 100,
  parameter int unsigned RND_W          = 16,
  parameter logic [RND_W-1:0] TAPS      = 16'hB400,
  parameter logic [RND_W-1:0] SEED      = 1,
  parameter int unsigned COORD_W        = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [COORD_W-1:0] rect1_left_i,
  input  logic [COORD_W-1:0] rect1_right_i,
  input  logic [COORD_W-1:0] rect1_top_i,
  input  logic [COORD_W-1:0] rect1_bottom_i,
  input  logic [COORD_W-1:0] rect2_left_i,
  input  logic [COORD_W-1:0] rect2_right_i,
  input  logic [COORD_W-1:0] rect2_top_i,
  input  logic [COORD_W-1:0] rect2_bottom_i,
  output logic               collision_o,
  output logic               strobe_o,
  output logic [RND_W-1:0]   rnd_num_o
);

  localparam int unsigned DIV_RAW = CLK_FREQ_HZ / STROBE_FREQ_HZ;
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  // ---------------- strobe ----------------
  logic [CNT_W-1:0] strobe_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      strobe_cnt <= '0;
      strobe_o   <= 1'b0;
    end else if (strobe_cnt == CNT_MAX) begin
      strobe_cnt <= '0;
      strobe_o   <= 1'b1;
    end else begin
      strobe_cnt <= strobe_cnt + CNT_W'(1);
      strobe_o   <= 1'b0;
    end
  end

  // ---------------- collision ----------------
  logic rect1_valid;
  logic rect2_valid;
  logic overlap;

  // Degenerate rectangles are rejected explicitly: the edge tests alone can
  // still pass when one rectangle has left >= right.
  always_comb begin
    rect1_valid = (rect1_left_i < rect1_right_i) && (rect1_top_i < rect1_bottom_i);
    rect2_valid = (rect2_left_i < rect2_right_i) && (rect2_top_i < rect2_bottom_i);
    overlap     = 1'b0;
`ifdef GAME_PRIMITIVES_COLL_INCLUSIVE_EN
    if ((rect1_left_i   <= rect2_right_i)  &&
        (rect1_right_i  >= rect2_left_i)   &&
        (rect1_top_i    <= rect2_bottom_i) &&
        (rect1_bottom_i >= rect2_top_i))
      overlap = rect1_valid && rect2_valid;
`else
    if ((rect1_left_i   < rect2_right_i)  &&
        (rect1_right_i  > rect2_left_i)   &&
        (rect1_top_i    < rect2_bottom_i) &&
        (rect1_bottom_i > rect2_top_i))
      overlap = rect1_valid && rect2_valid;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) collision_o <= 1'b0;
    else        collision_o <= overlap;
  end

  // ---------------- LFSR ----------------
  logic [RND_W-1:0] lfsr;
  logic [RND_W-1:0] lfsr_next;
  logic             feedback;

  always_comb begin
    feedback  = ^(lfsr & TAPS);
    lfsr_next = {lfsr[RND_W-2:0], feedback};
    if (lfsr == '0) lfsr_next = SEED;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr <= SEED;
    else        lfsr <= lfsr_next;
  end

  assign rnd_num_o = lfsr;

endmodule

// File: tb/tb_game_primitives.sv
// Self-checking bench for game_primitives: reference model compared every cycle plus directed literal checks.
module tb_game_primitives;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned STB_HZ = 1;
  localparam int unsigned DIV    = (CLK_HZ / STB_HZ < 1) ? 1 : CLK_HZ / STB_HZ;
  localparam logic [15:0] TAPS_M = 16'hB400;
  localparam logic [15:0] SEED_M = 16'h0001;
`ifdef GAME_PRIMITIVES_COLL_INCLUSIVE_EN
  localparam logic INCL = 1'b1;
`else
  localparam logic INCL = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [9:0]  l1 = '0, r1 = '0, t1 = '0, b1 = '0;
  logic [9:0]  l2 = '0, r2 = '0, t2 = '0, b2 = '0;
  logic        collision_o;
  logic        strobe_o;
  logic [15:0] rnd_num_o;

  int n_checks = 0;
  int n_fail   = 0;

  game_primitives #(
    .CLK_FREQ_HZ(CLK_HZ),
    .STROBE_FREQ_HZ(STB_HZ)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rect1_left_i(l1), .rect1_right_i(r1), .rect1_top_i(t1), .rect1_bottom_i(b1),
    .rect2_left_i(l2), .rect2_right_i(r2), .rect2_top_i(t2), .rect2_bottom_i(b2),
    .collision_o(collision_o),
    .strobe_o(strobe_o),
    .rnd_num_o(rnd_num_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic overlap_ref(input int a_l, a_r, a_t, a_b, input int c_l, c_r, c_t, c_b);
    if (a_l >= a_r || a_t >= a_b || c_l >= c_r || c_t >= c_b) return 1'b0;
    if (INCL) return (a_l <= c_r) && (a_r >= c_l) && (a_t <= c_b) && (a_b >= c_t);
    return (a_l < c_r) && (a_r > c_l) && (a_t < c_b) && (a_b > c_t);
  endfunction

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic fb;
    if (s == 16'h0) return SEED_M;
    fb = 1'b0;
    for (int i = 0; i < 16; i++)
      if (TAPS_M[i] && s[i]) fb = ~fb;
    return {s[14:0], fb};
  endfunction

  // Model: strobe from edges since release, collision from last-sampled inputs, LFSR by rule.
  int          since = 0;
  logic        e_strobe = 1'b0;
  logic        e_coll = 1'b0;
  logic [15:0] e_rnd = SEED_M;
  logic        check_en = 1'b0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      since    <= 0;
      e_strobe <= 1'b0;
      e_coll   <= 1'b0;
      e_rnd    <= SEED_M;
    end else begin
      since    <= since + 1;
      e_strobe <= ((since + 1) % DIV) == 0;
      e_coll   <= overlap_ref(l1, r1, t1, b1, l2, r2, t2, b2);
      e_rnd    <= lfsr_ref(e_rnd);
    end
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      check("model_strobe", strobe_o, e_strobe);
      check("model_collision", collision_o, e_coll);
      check("model_rnd", rnd_num_o, e_rnd);
    end
  end

  task automatic set_rects(input int a_l, a_r, a_t, a_b, input int c_l, c_r, c_t, c_b);
    l1 = 10'(a_l); r1 = 10'(a_r); t1 = 10'(a_t); b1 = 10'(a_b);
    l2 = 10'(c_l); r2 = 10'(c_r); t2 = 10'(c_t); b2 = 10'(c_b);
  endtask

  initial begin
    int          period;
    logic        zero_seen;
    logic        exp_s;

    @(posedge clk_i);
    check_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_strobe", strobe_o, 0);
    check("reset_collision", collision_o, 0);
    check("reset_rnd", rnd_num_o, 16'h0001);

    rst_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i);
      #1;
      exp_s = (k < 15) ? (k % 10 == 0) : (k > 16 && ((k - 16) % 10) == 0);
      check("strobe_directed", strobe_o, exp_s);
      case (k)
        1:  check("rnd_edge1", rnd_num_o, 16'h0002);
        2:  check("rnd_edge2", rnd_num_o, 16'h0004);
        3:  set_rects(620, 625, 200, 260, 622, 630, 240, 250);
        4:  begin
              check("coll_overlap", collision_o, 1);
              set_rects(620, 625, 200, 260, 625, 630, 240, 250);
            end
        5:  begin
              check("coll_touch_x", collision_o, INCL);
              set_rects(620, 625, 200, 260, 622, 630, 150, 200);
            end
        6:  begin
              check("coll_touch_y", collision_o, INCL);
              set_rects(630, 620, 200, 260, 600, 700, 100, 300);
            end
        7:  begin
              check("coll_degenerate", collision_o, 0);
              set_rects(620, 625, 200, 260, 622, 630, 240, 250);
            end
        8:  check("coll_restore", collision_o, 1);
        14: begin
              check("coll_before_reset", collision_o, 1);
              rst_i = 1'b0;
              #1;
              check("async_strobe", strobe_o, 0);
              check("async_collision", collision_o, 0);
              check("async_rnd", rnd_num_o, 16'h0001);
            end
        16: rst_i = 1'b1;
        17: begin
              check("rnd_after_rereset", rnd_num_o, 16'h0002);
              check("coll_after_rereset", collision_o, 1);
            end
        default: ;
      endcase
    end

    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    period    = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk_i);
      #1;
      if (rnd_num_o == 16'h0) zero_seen = 1'b1;
      if (rnd_num_o == 16'h0001) begin
        period = i;
        break;
      end
    end
    check("lfsr_period", period, 65535);
    check("lfsr_no_zero", zero_seen, 0);

    @(negedge clk_i);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
